// File: rtl/hazard_pkg.sv
// Shared definitions for the load-use hazard scoreboard:
// register encodings and counter sizing.
package hazard_pkg;

   localparam int REG_AW_DEF = 4;

   typedef enum logic [3:0] {
      R0 = 4'd0,
      R1 = 4'd1,
      R2 = 4'd2,
      R3 = 4'd3,
      R4 = 4'd4,
      R5 = 4'd5,
      R6 = 4'd6,
      R7 = 4'd7,
      SP = 4'd8,
      T  = 4'd9,
      IH = 4'd10,
      RA = 4'd11
   } reg_e;

   // Countdown width; a latency of zero still needs one storage bit.
   function automatic int cnt_w(input int lat);
      int w;
      w = $clog2(lat + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and pipeline-control bundle between
// the decode stage and the hazard scoreboard.
interface hazard_scoreboard_if #(
   parameter int REG_AW = 4,
   parameter int STAT_W = 16
);

   logic                   id_valid;
   logic                   id_src0_en;
   logic [REG_AW-1:0]      id_src0_addr;
   logic                   id_src1_en;
   logic [REG_AW-1:0]      id_src1_addr;
   logic                   id_dst_en;
   logic [REG_AW-1:0]      id_dst_addr;
   logic                   id_is_load;
   logic                   mem_busy;
   logic                   flush;
   logic                   stat_clr;

   logic                   pc_write;
   logic                   ifid_write;
   logic                   idex_bubble;
   logic [STAT_W-1:0]      stall_cycles;
   logic [2**REG_AW-1:0]   busy_vec;

   modport master (
      output id_valid,
      output id_src0_en,
      output id_src0_addr,
      output id_src1_en,
      output id_src1_addr,
      output id_dst_en,
      output id_dst_addr,
      output id_is_load,
      output mem_busy,
      output flush,
      output stat_clr,
      input  pc_write,
      input  ifid_write,
      input  idex_bubble,
      input  stall_cycles,
      input  busy_vec
   );

   modport slave (
      input  id_valid,
      input  id_src0_en,
      input  id_src0_addr,
      input  id_src1_en,
      input  id_src1_addr,
      input  id_dst_en,
      input  id_dst_addr,
      input  id_is_load,
      input  mem_busy,
      input  flush,
      input  stat_clr,
      output pc_write,
      output ifid_write,
      output idex_bubble,
      output stall_cycles,
      output busy_vec
   );

endinterface

// File: rtl/hazard_busy_counter.sv
// One register's pending-load countdown; a new load
// overrides the decrement in the same cycle.
module hazard_busy_counter #(
   parameter int CNT_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_dec_en,
   input  logic             i_load_en,
   input  logic [CNT_W-1:0] i_load_val,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_busy
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_nz;

   assign w_nz   = |r_cnt;
   assign o_cnt  = r_cnt;
   assign o_busy = w_nz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load_en) begin
         r_cnt <= i_load_val;
      end else if (i_dec_en && w_nz) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register busy scoreboard driving PC, IF/ID and
// ID/EX control for load-use, memory freeze and flush.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_AW   = REG_AW_DEF,
   parameter int LOAD_LAT = 1,
   parameter int STAT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   hazard_scoreboard_if.slave bus
);

   localparam int NREG  = 2**REG_AW;
   localparam int CNT_W = cnt_w(LOAD_LAT);
   localparam logic [CNT_W-1:0] LAT_V = CNT_W'(LOAD_LAT);

   logic [NREG-1:0]  w_busy;
   logic [NREG-1:0]  w_nz;
   logic [CNT_W-1:0] w_cnt [NREG];
   logic             w_src0_hit;
   logic             w_src1_hit;
   logic             w_hazard;
   logic             w_stall;
   logic             w_issue;
   logic             w_wr;
   logic             w_dec_en;
   logic [CNT_W-1:0] w_ld_val;
   logic             w_stat_inc;
   logic [STAT_W-1:0] r_stall;

   assign w_src0_hit = bus.id_src0_en & w_busy[bus.id_src0_addr];
   assign w_src1_hit = bus.id_src1_en & w_busy[bus.id_src1_addr];
   assign w_hazard   = bus.id_valid & (w_src0_hit | w_src1_hit);
   assign w_stall    = w_hazard | bus.mem_busy;

   assign w_issue = bus.id_valid & ~w_hazard
                  & ~bus.mem_busy & ~bus.flush;
   assign w_wr     = w_issue & bus.id_dst_en;
   assign w_dec_en = ~bus.mem_busy;
   // ALU writers clear the entry: forwarding beats the older load.
   assign w_ld_val = bus.id_is_load ? LAT_V : '0;

   assign bus.pc_write    = ~w_stall;
   assign bus.ifid_write  = ~w_stall;
   assign bus.idex_bubble = ~bus.mem_busy & (w_hazard | bus.flush);
   assign bus.busy_vec    = w_nz;
   assign bus.stall_cycles = r_stall;

   for (genvar r = 0; r < NREG; r++) begin : g_reg
      logic w_ld_en;

      assign w_ld_en = w_wr &
                       (bus.id_dst_addr == REG_AW'(r));
      assign w_nz[r] = |w_cnt[r];

      hazard_busy_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk        (clk),
         .rst_n      (rst),
         .i_dec_en   (w_dec_en),
         .i_load_en  (w_ld_en),
         .i_load_val (w_ld_val),
         .o_cnt      (w_cnt[r]),
         .o_busy     (w_busy[r])
      );

      a_cnt_bound : assert property (
         @(posedge clk) disable iff (!rst)
         w_cnt[r] <= LAT_V
      );
   end

   assign w_stat_inc = w_hazard & ~bus.mem_busy & ~(&r_stall);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall <= '0;
      end else if (bus.stat_clr) begin
         r_stall <= '0;
      end else if (w_stat_inc) begin
         r_stall <= r_stall + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard at LOAD_LAT 1, 2 and 0,
// driven in lockstep against a timestamp reference model.
module tb_hazard_scoreboard;
   import hazard_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic       id_valid, s0en, s1en, dst_en, is_load;
   logic [3:0] s0, s1, dst;
   logic       mem_busy, flush, stat_clr;

   int total = 0;
   int bad   = 0;

   hazard_scoreboard_if #(.REG_AW(4), .STAT_W(16)) ifA ();
   hazard_scoreboard_if #(.REG_AW(4), .STAT_W(4))  ifB ();
   hazard_scoreboard_if #(.REG_AW(4), .STAT_W(8))  ifC ();

   assign ifA.id_valid = id_valid;     assign ifB.id_valid = id_valid;
   assign ifA.id_src0_en = s0en;       assign ifB.id_src0_en = s0en;
   assign ifA.id_src0_addr = s0;       assign ifB.id_src0_addr = s0;
   assign ifA.id_src1_en = s1en;       assign ifB.id_src1_en = s1en;
   assign ifA.id_src1_addr = s1;       assign ifB.id_src1_addr = s1;
   assign ifA.id_dst_en = dst_en;      assign ifB.id_dst_en = dst_en;
   assign ifA.id_dst_addr = dst;       assign ifB.id_dst_addr = dst;
   assign ifA.id_is_load = is_load;    assign ifB.id_is_load = is_load;
   assign ifA.mem_busy = mem_busy;     assign ifB.mem_busy = mem_busy;
   assign ifA.flush = flush;           assign ifB.flush = flush;
   assign ifA.stat_clr = stat_clr;     assign ifB.stat_clr = stat_clr;
   assign ifC.id_valid = id_valid;
   assign ifC.id_src0_en = s0en;
   assign ifC.id_src0_addr = s0;
   assign ifC.id_src1_en = s1en;
   assign ifC.id_src1_addr = s1;
   assign ifC.id_dst_en = dst_en;
   assign ifC.id_dst_addr = dst;
   assign ifC.id_is_load = is_load;
   assign ifC.mem_busy = mem_busy;
   assign ifC.flush = flush;
   assign ifC.stat_clr = stat_clr;

   hazard_scoreboard #(.REG_AW(4), .LOAD_LAT(1), .STAT_W(16)) dutA (
      .clk (clk), .rst (rst), .bus (ifA.slave));
   hazard_scoreboard #(.REG_AW(4), .LOAD_LAT(2), .STAT_W(4)) dutB (
      .clk (clk), .rst (rst), .bus (ifB.slave));
   hazard_scoreboard #(.REG_AW(4), .LOAD_LAT(0), .STAT_W(8)) dutC (
      .clk (clk), .rst (rst), .bus (ifC.slave));

   always #5 clk = ~clk;

   // Model: a load issued at un-frozen cycle t makes its register
   // readable from cycle t+LAT+1; frozen cycles do not advance time.
   int     lat [3] = '{1, 2, 0};
   int     smax [3] = '{65535, 15, 255};
   longint tnow [3];
   longint ready [3][16];
   int     stat [3];

   function automatic bit m_busy(int k, logic [3:0] r);
      return ready[k][r] > tnow[k];
   endfunction

   function automatic bit m_hazard(int k);
      return id_valid && ((s0en && m_busy(k, s0)) ||
                          (s1en && m_busy(k, s1)));
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 3; k++) begin
         tnow[k] = 0;
         stat[k] = 0;
         for (int r = 0; r < 16; r++) ready[k][r] = 0;
      end
   endfunction

   function automatic void model_edge();
      for (int k = 0; k < 3; k++) begin
         bit h;
         h = m_hazard(k);
         if (stat_clr) stat[k] = 0;
         else if (!mem_busy && h && stat[k] < smax[k]) stat[k]++;
         if (!mem_busy) begin
            if (id_valid && !h && !flush && dst_en)
               ready[k][dst] = is_load ? tnow[k] + lat[k] + 1 : 0;
            tnow[k]++;
         end
      end
   endfunction

   function automatic logic [34:0] expv(int k);
      bit h;
      logic [15:0] bv;
      h = m_hazard(k);
      for (int r = 0; r < 16; r++) bv[r] = m_busy(k, 4'(r));
      return {~(h | mem_busy), ~(h | mem_busy),
              ~mem_busy & (h | flush), bv, 16'(stat[k])};
   endfunction

   function automatic logic [34:0] obs(int k);
      case (k)
         0: return {ifA.pc_write, ifA.ifid_write, ifA.idex_bubble,
                    ifA.busy_vec, ifA.stall_cycles};
         1: return {ifB.pc_write, ifB.ifid_write, ifB.idex_bubble,
                    ifB.busy_vec, 12'd0, ifB.stall_cycles};
         default: return {ifC.pc_write, ifC.ifid_write,
                          ifC.idex_bubble, ifC.busy_vec,
                          8'd0, ifC.stall_cycles};
      endcase
   endfunction

   task automatic set_idle();
      id_valid = 0; s0en = 0; s1en = 0; dst_en = 0; is_load = 0;
      s0 = 0; s1 = 0; dst = 0;
      mem_busy = 0; flush = 0; stat_clr = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      set_idle();
      rst = 0;
      model_reset();
      @(negedge clk);
      rst = 1;
   endtask

   task automatic issue_load(logic [3:0] r);
      set_idle();
      id_valid = 1; dst_en = 1; dst = r; is_load = 1;
   endtask

   task automatic consumer(logic [3:0] a, bit use1);
      set_idle();
      id_valid = 1;
      if (use1) begin s1en = 1; s1 = a; end
      else begin s0en = 1; s0 = a; end
   endtask

   task automatic test_reset();
      set_idle();
      rst = 0;
      model_reset();
      flush = 1;
      #1;
      total++;
      if ({ifA.pc_write, ifA.ifid_write, ifA.idex_bubble} !== 3'b111) begin
         bad++;
         $display("FAIL reset_ctl got=%b exp=111",
                  {ifA.pc_write, ifA.ifid_write, ifA.idex_bubble});
      end
      total++;
      if (ifA.busy_vec !== 16'h0 || ifA.stall_cycles !== 16'h0) begin
         bad++;
         $display("FAIL reset_state busy=%h stall=%h exp=0",
                  ifA.busy_vec, ifA.stall_cycles);
      end
      mem_busy = 1;
      #1;
      total++;
      if ({ifA.pc_write, ifA.idex_bubble} !== 2'b00) begin
         bad++;
         $display("FAIL reset_membusy got=%b exp=00",
                  {ifA.pc_write, ifA.idex_bubble});
      end
      @(negedge clk);
      set_idle();
      rst = 1;
   endtask

   task automatic test_load_use();
      do_reset();
      issue_load(4'(R3));
      #1;
      total++;
      if (ifA.pc_write !== 1'b1) begin
         bad++;
         $display("FAIL lu_load got=%b exp=1", ifA.pc_write);
      end
      tick();
      consumer(4'(R3), 0);
      dst_en = 1; dst = 6;
      #1;
      total++;
      if ({ifA.pc_write, ifA.ifid_write, ifA.idex_bubble} !== 3'b001) begin
         bad++;
         $display("FAIL lu_bubble got=%b exp=001",
                  {ifA.pc_write, ifA.ifid_write, ifA.idex_bubble});
      end
      total++;
      if (ifC.pc_write !== 1'b1) begin
         bad++;
         $display("FAIL lu_lat0 got=%b exp=1", ifC.pc_write);
      end
      tick();
      #1;
      total++;
      if (ifA.pc_write !== 1'b1 || ifA.stall_cycles !== 16'd1) begin
         bad++;
         $display("FAIL lu_issue pc=%b stall=%0d exp pc=1 stall=1",
                  ifA.pc_write, ifA.stall_cycles);
      end
      total++;
      if (ifB.pc_write !== 1'b0) begin
         bad++;
         $display("FAIL lu_lat2_second got=%b exp=0", ifB.pc_write);
      end
      tick();
      set_idle();
   endtask

   task automatic test_lat2_sp();
      logic [2:0] seen;
      do_reset();
      issue_load(4'(SP));
      tick();
      consumer(4'(SP), 1);
      for (int i = 0; i < 3; i++) begin
         #1;
         seen[2-i] = ifB.busy_vec[8];
         if (i < 2) begin
            total++;
            if (ifB.idex_bubble !== 1'b1) begin
               bad++;
               $display("FAIL sp_bubble%0d got=%b exp=1", i,
                        ifB.idex_bubble);
            end
         end
         tick();
      end
      total++;
      if (seen !== 3'b110) begin
         bad++;
         $display("FAIL sp_busy_seq got=%b exp=110", seen);
      end
      issue_load(4'(SP));
      tick();
      set_idle();
      id_valid = 1;
      tick();
      consumer(4'(SP), 1);
      #1;
      total++;
      if (ifB.idex_bubble !== 1'b1) begin
         bad++;
         $display("FAIL sp_gap_bubble got=%b exp=1", ifB.idex_bubble);
      end
      tick();
      #1;
      total++;
      if (ifB.pc_write !== 1'b1) begin
         bad++;
         $display("FAIL sp_gap_issue got=%b exp=1", ifB.pc_write);
      end
      tick();
      set_idle();
   endtask

   task automatic test_mem_busy();
      do_reset();
      issue_load(4'(R2));
      tick();
      consumer(4'(R2), 0);
      mem_busy = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (ifA.idex_bubble !== 1'b0 || ifA.pc_write !== 1'b0 ||
             ifA.busy_vec[2] !== 1'b1 || ifA.stall_cycles !== 16'd0) begin
            bad++;
            $display("FAIL mb_hold%0d bub=%b pc=%b busy=%b stall=%0d exp 0 0 1 0",
                     i, ifA.idex_bubble, ifA.pc_write,
                     ifA.busy_vec[2], ifA.stall_cycles);
         end
         tick();
      end
      mem_busy = 0;
      #1;
      total++;
      if (ifA.idex_bubble !== 1'b1) begin
         bad++;
         $display("FAIL mb_release got=%b exp=1", ifA.idex_bubble);
      end
      tick();
      #1;
      total++;
      if (ifA.pc_write !== 1'b1 || ifA.stall_cycles !== 16'd1) begin
         bad++;
         $display("FAIL mb_after pc=%b stall=%0d exp pc=1 stall=1",
                  ifA.pc_write, ifA.stall_cycles);
      end
      tick();
      set_idle();
   endtask

   task automatic test_flush();
      do_reset();
      issue_load(4'(R5));
      tick();
      consumer(4'(R5), 0);
      flush = 1;
      #1;
      total++;
      if ({ifA.pc_write, ifA.idex_bubble} !== 2'b01) begin
         bad++;
         $display("FAIL fl_kill got=%b exp=01",
                  {ifA.pc_write, ifA.idex_bubble});
      end
      tick();
      flush = 0;
      #1;
      total++;
      if (ifA.pc_write !== 1'b1 || ifA.busy_vec[5] !== 1'b0) begin
         bad++;
         $display("FAIL fl_next pc=%b busy5=%b exp pc=1 busy5=0",
                  ifA.pc_write, ifA.busy_vec[5]);
      end
      tick();
      set_idle();
   endtask

   task automatic test_waw();
      do_reset();
      issue_load(4'(R4));
      tick();
      set_idle();
      id_valid = 1; dst_en = 1; dst = 4'(R4);
      #1;
      total++;
      if (ifA.pc_write !== 1'b1) begin
         bad++;
         $display("FAIL waw_alu got=%b exp=1", ifA.pc_write);
      end
      tick();
      consumer(4'(R4), 0);
      #1;
      total++;
      if (ifA.pc_write !== 1'b1 || ifA.busy_vec !== 16'h0 ||
          ifB.pc_write !== 1'b1) begin
         bad++;
         $display("FAIL waw_reader pcA=%b busyA=%h pcB=%b exp 1 0000 1",
                  ifA.pc_write, ifA.busy_vec, ifB.pc_write);
      end
      tick();
      set_idle();
   endtask

   task automatic test_sat_clr_rst();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         issue_load(4'(R1));
         tick();
         consumer(4'(R1), 0);
         tick();
         tick();
      end
      set_idle();
      #1;
      total++;
      if (ifA.stall_cycles !== 16'd10 || ifB.stall_cycles !== 4'hF ||
          ifC.stall_cycles !== 8'd0) begin
         bad++;
         $display("FAIL sat A=%0d B=%0d C=%0d exp 10 15 0",
                  ifA.stall_cycles, ifB.stall_cycles, ifC.stall_cycles);
      end
      stat_clr = 1;
      tick();
      stat_clr = 0;
      #1;
      total++;
      if (ifA.stall_cycles !== 16'd0 || ifB.stall_cycles !== 4'd0) begin
         bad++;
         $display("FAIL stat_clr A=%0d B=%0d exp 0 0",
                  ifA.stall_cycles, ifB.stall_cycles);
      end
      issue_load(4'(R6));
      tick();
      consumer(4'(R6), 0);
      #1;
      total++;
      if (ifB.pc_write !== 1'b0) begin
         bad++;
         $display("FAIL rst_pre got=%b exp=0", ifB.pc_write);
      end
      rst = 0;
      model_reset();
      #1;
      total++;
      if (ifA.busy_vec !== 16'h0 || ifB.busy_vec !== 16'h0 ||
          ifB.pc_write !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid A=%h B=%h pcB=%b exp 0000 0000 1",
                  ifA.busy_vec, ifB.busy_vec, ifB.pc_write);
      end
      @(negedge clk);
      rst = 1;
      #1;
      total++;
      if (ifA.pc_write !== 1'b1 || ifB.pc_write !== 1'b1) begin
         bad++;
         $display("FAIL rst_after pcA=%b pcB=%b exp 1 1",
                  ifA.pc_write, ifB.pc_write);
      end
      tick();
      set_idle();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 300; n++) begin
         id_valid = ($urandom_range(0, 9) != 0);
         s0en = $urandom_range(0, 1);
         s1en = $urandom_range(0, 1);
         s0 = ($urandom_range(0, 3) == 0) ? 4'(8 + $urandom_range(0, 3))
                                          : 4'($urandom_range(0, 5));
         s1 = ($urandom_range(0, 4) == 0) ? s0 : 4'($urandom_range(0, 5));
         dst_en = ($urandom_range(0, 3) != 0);
         dst = ($urandom_range(0, 3) == 0) ? 4'(8 + $urandom_range(0, 3))
                                           : 4'($urandom_range(0, 5));
         is_load = $urandom_range(0, 1);
         mem_busy = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 9) == 0);
         stat_clr = ($urandom_range(0, 39) == 0);
         #1;
         for (int k = 0; k < 3; k++) begin
            total++;
            if (obs(k) !== expv(k)) begin
               bad++;
               $display("FAIL rand k=%0d n=%0d got=%h exp=%h",
                        k, n, obs(k), expv(k));
            end
         end
         tick();
      end
      set_idle();
   endtask

   initial begin
      set_idle();
      model_reset();
      test_reset();
      test_load_use();
      test_lat2_sp();
      test_mem_busy();
      test_flush();
      test_waw();
      test_sat_clr_rst();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised load-use hazard unit for the in-order pipeline. It replaces fixed single-bubble Rx/Ry compare logic with a per-register busy scoreboard.
- Each architectural register, including the special registers SP, T, IH and RA, carries a countdown. The countdown gives the cycles left until that register's pending load result can be forwarded.
- The block sits beside the ID stage and drives PC, IF/ID and ID/EX control. It also handles memory-busy freeze, branch flush and a stall-cycle statistic.

Parameters:
- REG_AW, 4, register address width; 2**REG_AW scoreboard entries.
- LOAD_LAT, 1, bubbles needed between a load and a dependent consumer; 0 means full forwarding and never stall.
- STAT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_src0_en  in  1  source 0 is read
- id_src0_addr  in  REG_AW  source 0 register
- id_src1_en  in  1  source 1 is read
- id_src1_addr  in  REG_AW  source 1 register
- id_dst_en  in  1  instruction writes a register
- id_dst_addr  in  REG_AW  destination register
- id_is_load  in  1  destination is written from memory (LW/LW_SP)
- mem_busy  in  1  structural stall from shared SRAM; freezes the whole pipeline
- flush  in  1  taken branch/jump; kill the ID instruction
- stat_clr  in  1  synchronous clear of the stall counter
- pc_write  out  1  PC update enable (1 = advance)
- ifid_write  out  1  IF/ID load enable (1 = load)
- idex_bubble  out  1  load NOP into ID/EX
- stall_cycles  out  STAT_W  saturating count of hazard bubbles
- busy_vec  out  2**REG_AW  bit r = cnt[r]!=0, for debug

Behaviour:
- Reset is asynchronous, active-low.
  - Reset values: all cnt[r]=0 and stall_cycles=0.
  - With cleared state the outputs give pc_write=1, ifid_write=1 and idex_bubble=flush&~mem_busy.
- State: cnt[r], CNT_W=$clog2(LOAD_LAT+1) bits, minimum 1 bit. When LOAD_LAT=0 all cnt stay 0 and are never written non-zero.
- The combinational terms below have zero-cycle latency from the inputs.
  - hazard = id_valid & ((id_src0_en & busy[src0]) | (id_src1_en & busy[src1])).
  - stall = hazard | mem_busy.
  - pc_write = ifid_write = ~stall.
  - idex_bubble = ~mem_busy & (hazard | flush). While mem_busy, ID/EX holds and no bubble is inserted.
  - issue = id_valid & ~hazard & ~mem_busy & ~flush.
- Sequential update on the clk rising edge, when mem_busy=0:
  - Every cnt[r]!=0 decrements by 1.
  - If issue & id_dst_en & id_is_load: cnt[dst] <= LOAD_LAT. This overrides that entry's decrement in the same cycle.
  - If issue & id_dst_en & ~id_is_load: cnt[dst] <= 0. The younger ALU result wins WAW via forwarding.
- mem_busy=1: all cnt hold and stall_cycles holds.
- flush with hazard: idex_bubble=1, pc_write=0, ifid_write=0. The PC source mux gives the branch target priority over pc_write.
  - Nothing is issued.
  - Older pending loads keep their counters; they are not cancelled.
- Same-register sources (src0==src1) are a single dependency; no double count.
- The load instruction's own sources are checked before it issues, like any consumer.
- stall_cycles increments on each cycle with hazard & ~mem_busy, saturating at all-ones. stat_clr has priority and sets it to 0.
- With LOAD_LAT=1, a load then a dependent instruction gives exactly 1 bubble. With LOAD_LAT=2, the back-to-back consumer gets 2 bubbles and one independent instruction in between reduces this to 1.
- Reset asserted mid-stall clears all counters immediately; the next instruction after release sees no hazard.

Decomposition:
- hazard_pkg holds:
  - REG_AW default;
  - register encodings R0..R7=0..7, SP=8, T=9, IH=10, RA=11;
  - CNT_W function.
- Sub-module hazard_busy_counter (one per register, generated): inputs dec_en, load_en, load_val; outputs cnt and busy. It owns the load-overrides-decrement priority.

Test Plan:
1. LOAD_LAT=1: LW dst=R3, then ADDU with src0=R3. Response: cycle 1 hazard, so pc_write=0, ifid_write=0, idex_bubble=1. Cycle 2 issues, and stall_cycles=1.
2. LOAD_LAT=2: LW dst=SP(8), then consumer src1=8. Response: 2 bubble cycles and busy_vec[8] goes 1,1,0. Inserting an independent instruction in between gives 1 bubble.
3. LW R2 pending and mem_busy=1 held for 3 cycles with a dependent instruction in ID. Response: no bubble during busy, cnt[2] frozen at 1, stall_cycles unchanged. After release, 1 bubble.
4. LW R5 then a dependent instruction with flush=1 in the same cycle. Response: idex_bubble=1, no issue, cnt[5] decrements to 0. The next fetched instruction reading R5 does not stall.
5. LW R4 followed by ALU dst=R4 (independent sources). Response: cnt[4] cleared, and a subsequent reader of R4 has no stall.
6. stall_cycles forced near 2**STAT_W-1 with repeated hazards: saturates at 0xFFFF. stat_clr gives 0 next cycle. rst low mid-stall: busy_vec=0 immediately.
